// File: rtl/reg_share_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for reg_share_arb.
`default_nettype none

package reg_share_arb_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_LOCK = 8;

  // The search always works on the largest supported requester count.
  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping at n.
  function automatic rr_pick_t rr_find_first(input logic [MAX_NREQ-1:0] req,
                                             input logic [PTR_W-1:0]    ptr,
                                             input int unsigned         n);
    rr_pick_t         r;
    logic [PTR_W-1:0] idx;
    r   = '0;
    idx = ptr;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < n) begin
        if (!r.found && req[idx]) begin
          r.found = 1'b1;
          r.idx   = idx;
        end
        idx = (idx == PTR_W'(n - 1)) ? '0 : idx + 1'b1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_share_arb_shared_reg.sv
// WIDTH-bit D flip-flop bank with load enable and synchronous active-low reset.
`default_nettype none

module reg_share_arb_shared_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/reg_share_arb.sv
// Round-robin arbiter and write sequencer for one shared register.
// Optional REG_ARB_LOCK_EN adds a lock port that holds ownership up to MAX_LOCK grants.
`default_nettype none

module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   wdata_i,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock_i,
`endif
  output logic [NREQ-1:0]         gnt_o,
  output logic [WIDTH-1:0]        q_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    valid_o
);

  localparam int IDXW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0]    win_q, win_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    owner_q;
  logic               valid_q;

  logic [NREQ-1:0]    elig;
  logic [MAX_NREQ-1:0] elig_ext;
  logic [IDXW-1:0]    win_nxt;
  logic [PTR_W-1:0]   base;
  rr_pick_t           pick;
  logic               load;
  logic               hold;
  logic [WIDTH-1:0]   wsel;

`ifdef REG_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic [LCW-1:0] lcnt_q, lcnt_d;
`endif

  assign win_nxt = (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  // The current winner is excluded and the search restarts just above it.
  always_comb begin
    elig     = req_i;
    base     = '0;
    base[IDXW-1:0] = ptr_q;
    load     = 1'b0;
    hold     = 1'b0;
    if (state_q == ST_GRANT) begin
      elig           = req_i & ~gnt_q;
      base[IDXW-1:0] = win_nxt;
      load           = 1'b1;
`ifdef REG_ARB_LOCK_EN
      if (lock_i[win_q] && req_i[win_q] && (lcnt_q < LCW'(MAX_LOCK - 1))) begin
        hold = 1'b1;
      end
`endif
    end
    elig_ext           = '0;
    elig_ext[NREQ-1:0] = elig;
  end

  assign pick = rr_find_first(elig_ext, base, NREQ);

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    win_d   = win_q;
    ptr_d   = ptr_q;
`ifdef REG_ARB_LOCK_EN
    lcnt_d  = lcnt_q;
`endif
    if (hold) begin
      state_d = ST_GRANT;
      gnt_d   = gnt_q;
`ifdef REG_ARB_LOCK_EN
      lcnt_d  = lcnt_q + LCW'(1);
`endif
    end else begin
      if (state_q == ST_GRANT) begin
        ptr_d = win_nxt;
      end
`ifdef REG_ARB_LOCK_EN
      lcnt_d = '0;
`endif
      state_d = pick.found ? ST_GRANT : ST_IDLE;
      for (int i = 0; i < NREQ; i++) begin
        if (pick.found && (pick.idx == PTR_W'(i))) begin
          gnt_d[i] = 1'b1;
          win_d    = IDXW'(i);
        end
      end
    end
  end

  always_comb begin
    wsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == IDXW'(i)) begin
        wsel = wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      if (load) begin
        owner_q <= win_q;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef REG_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      lcnt_q <= '0;
    end else begin
      lcnt_q <= lcnt_d;
    end
  end
`endif

  reg_share_arb_shared_reg #(
    .WIDTH (WIDTH)
  ) u_shared_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .d_i    (wsel),
    .q_o    (q_o)
  );

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb (NREQ=4, WIDTH=8); covers the lock path when REG_ARB_LOCK_EN is defined.
`default_nettype none

module tb_reg_share_arb;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] owner;
    logic       valid;
  } vec_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] owner;
    logic       valid;
  } exp_t;

  localparam logic [31:0] WDATA = 32'h44_A5_3C_11;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  lock;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        valid;

  int n_checks;
  int n_pass;
  exp_t sb[$];
  vec_t vecs[21];

  reg_share_arb #(
    .NREQ     (4),
    .WIDTH    (8),
    .MAX_LOCK (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .wdata_i (wdata),
`ifdef REG_ARB_LOCK_EN
    .lock_i  (lock),
`endif
    .gnt_o   (gnt),
    .q_o     (q),
    .owner_o (owner),
    .valid_o (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] slice(input int i);
    logic [31:0] w;
    w = WDATA;
    return w[i*8 +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " gnt"},   {28'd0, gnt},   {28'd0, e.gnt});
      check({tag, " q"},     {24'd0, q},     {24'd0, e.q});
      check({tag, " owner"}, {30'd0, owner}, {30'd0, e.owner});
      check({tag, " valid"}, {31'd0, valid}, {31'd0, e.valid});
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic step(input string tag, input logic r, input logic [3:0] rq,
                      input logic [3:0] lk, input exp_t e);
    rst  = r;
    req  = rq;
    lock = lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    req      = 4'b0000;
    lock     = 4'b0000;
    wdata    = WDATA;

    //            rst   req      lock     gnt      q      own  valid
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 8'h00, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b1};
    vecs[4]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1};
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b1};
    vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[8]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 8'h00, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 8'h11, 2'd0, 1'b1};
    vecs[10] = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 8'h3C, 2'd1, 1'b1};
    vecs[11] = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 8'hA5, 2'd2, 1'b1};
    vecs[12] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 8'h44, 2'd3, 1'b1};
    vecs[13] = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 8'h11, 2'd0, 1'b1};
    // Reset lands while requester 1 holds the grant: no write, pointer back to 0.
    vecs[14] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0};
    vecs[15] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 8'h00, 2'd0, 1'b0};
    vecs[16] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h11, 2'd0, 1'b1};
    vecs[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h11, 2'd0, 1'b1};
    // Requester 3 pulses alongside requester 1's winning cycle, then withdraws.
    vecs[18] = '{1'b1, 4'b1010, 4'b0000, 4'b0010, 8'h11, 2'd0, 1'b1};
    vecs[19] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 2'd1, 1'b1};
    vecs[20] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 2'd1, 1'b1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].lock,
           '{vecs[i].gnt, vecs[i].q, vecs[i].owner, vecs[i].valid});
    end

    // Fairness: all requesters for several rounds, expectations from a rotation model.
    step("fair_rst", 1'b0, 4'b1111, 4'b0000, '{4'b0000, 8'h00, 2'd0, 1'b0});
    for (int k = 0; k < 12; k++) begin
      exp_t e;
      e.gnt   = 4'(1 << (k % 4));
      e.q     = (k == 0) ? 8'h00 : slice((k - 1) % 4);
      e.owner = (k == 0) ? 2'd0 : 2'((k - 1) % 4);
      e.valid = (k != 0);
      step($sformatf("fair%0d", k), 1'b1, 4'b1111, 4'b0000, e);
    end

    // Data change on a non-granted slice while idle must not disturb q.
    step("idle_a", 1'b1, 4'b0000, 4'b0000, '{4'b0000, 8'h44, 2'd3, 1'b1});
    wdata = 32'hFF_FF_FF_FF;
    step("idle_b", 1'b1, 4'b0000, 4'b0000, '{4'b0000, 8'h44, 2'd3, 1'b1});
    wdata = WDATA;

`ifdef REG_ARB_LOCK_EN
    step("lock_rst", 1'b0, 4'b0000, 4'b0000, '{4'b0000, 8'h00, 2'd0, 1'b0});
    for (int k = 0; k < 8; k++) begin
      step($sformatf("lock%0d", k), 1'b1, 4'b1010, 4'b0010,
           '{4'b0010, (k == 0) ? 8'h00 : 8'h3C, (k == 0) ? 2'd0 : 2'd1, (k != 0)});
    end
    step("lock_release", 1'b1, 4'b1010, 4'b0010, '{4'b1000, 8'h3C, 2'd1, 1'b1});
    step("lock_after", 1'b1, 4'b0000, 4'b0000, '{4'b0000, 8'h44, 2'd3, 1'b1});
`endif

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter and write sequencer that shares one WIDTH-bit register, a bank of D flip-flops with synchronous active-low reset, among NREQ requesters. Each requester presents a request and a data word. The block grants one requester per cycle and loads that requester's word into the shared register. It sits between the requester logic and the shared storage and is the only writer of that register.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_LOCK, 8, maximum consecutive locked grants (used only with REG_ARB_LOCK_EN)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset; synchronous, active-low
- req  input  NREQ  request per requester
- wdata  input  NREQ*WIDTH  write data; slice i is requester i
- lock  input  NREQ  hold ownership (present only with REG_ARB_LOCK_EN)
- gnt  output  NREQ  registered one-hot grant; all zero when idle
- q  output  WIDTH  shared register contents
- owner  output  clog2(NREQ)  index of the last requester that wrote q
- valid  output  1  q has been written at least once since reset

## Operation
- Reset values: gnt=0, q=0, owner=0, valid=0, FSM=IDLE, pointer=0, lock count=0.
- rst=0 overrides every other input on that edge. A grant active during reset does not write.
- FSM state IDLE: gnt=0.
  - If any eligible req is high at the edge, go to GRANT and register the winner's one-hot gnt.
  - Otherwise stay in IDLE.
- FSM state GRANT: gnt is one-hot for requester w.
  - On the edge that ends this cycle: q<=wdata[w], owner<=w, valid<=1, pointer<=w+1 (mod NREQ).
  - The next winner is arbitrated on the same edge. If none is eligible, go to IDLE.
- Arbitration: search from pointer upward with wrap-around. The first requester with req=1 wins.
- In GRANT, the current winner w is excluded from the next arbitration (unless locked). A lone, continuously requesting requester is therefore granted every other cycle.
- Request withdrawal: dropping req before gnt is seen cancels the request. Once gnt is registered, the write happens whatever the state of req.
- Requesters must hold wdata stable while their gnt is high.

## Timing
- Latency from IDLE: req high before edge E0, gnt high in the cycle after E0, q updated at edge E1.
- With several requesters requesting, grants are issued back-to-back with one write per cycle.
- gnt, q, owner and valid are all registered outputs, with no combinational path from inputs.
- Fairness: with all requesters continuously requesting, each requester is granted once every NREQ cycles.

## Configuration
- REG_ARB_LOCK_EN defined:
  - Adds the lock port and a lock counter.
  - In GRANT, if lock[w]=1 and req[w]=1, the FSM stays in GRANT with the same w and writes every cycle.
  - The count increments on each locked repeat. After MAX_LOCK consecutive grants to w, lock is ignored for one arbitration and the count clears.
  - The pointer does not advance during locked repeats.
- REG_ARB_LOCK_EN undefined: there is no lock port or counter, and every grant lasts exactly one cycle.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, GRANT);
  - the default NREQ, WIDTH and MAX_LOCK constants;
  - the round-robin find-first function.
- One sub-module, shared_reg: a WIDTH-bit register built from D flip-flops, with load enable and synchronous active-low reset. It is instantiated once for q.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=4'b1111. Required: gnt=0, q=8'h00, valid=0, owner=0 throughout.
- Single requester: req[2]=1, wdata slice 2=8'hA5, starting from IDLE. Required: gnt=4'b0100 one cycle later, q=8'hA5, owner=2, valid=1 after the next edge. While req is held, gnt follows the sequence 0100, 0000, 0100.
- All requesters: req=4'b1111 just after reset. Required: gnt sequence 0001, 0010, 0100, 1000, 0001 with no gaps, and q tracks each granted slice.
- Reset mid-grant: rst=0 during a cycle with gnt=4'b0010 and wdata slice 1=8'h3C. Required: q=0, gnt=0 after that edge, and the next grant goes to requester 0.
- Withdrawal: req[3] pulses for one cycle while requester 1 is granted. Required: requester 3 is never granted, the FSM returns to IDLE, and q keeps requester 1's data.
- Lock (REG_ARB_LOCK_EN defined): lock[1]=req[1]=1 and req[3]=1. Required: gnt=4'b0010 for 8 consecutive cycles, then 4'b1000.
